// File: rtl/a2_bus_timing_master_if.sv
// Host request channel between a CPU-side requester and the A2 bus timing master.
`timescale 1ns/1ps
interface a2_bus_timing_master_if;
  logic        REQ;
  logic [15:0] REQ_ADDR;
  logic        REQ_WE;
  logic        REQ_AUX;
  logic [7:0]  REQ_WDATA;
  logic        BUSY;
  logic        ACK;
  logic [7:0]  RDATA;

  modport master (output REQ, REQ_ADDR, REQ_WE, REQ_AUX, REQ_WDATA,
                  input  BUSY, ACK, RDATA);
  modport slave  (input  REQ, REQ_ADDR, REQ_WE, REQ_AUX, REQ_WDATA,
                  output BUSY, ACK, RDATA);
endinterface

// File: rtl/a2_bus_timing_master.sv
// Apple IIe motherboard-side bus timing generator driving the aux-slot RAM card from C14M.
`timescale 1ns/1ps
module a2_bus_timing_master #(
  parameter int LONG_CYCLE_EN   = 1,
  parameter int CYCLES_PER_LINE = 65
) (
  input  logic        C14M,
  input  logic        RST,
  a2_bus_timing_master_if.slave host,
  output logic        PHI1,
  output logic        PHI0,
  output logic        Q3,
  output logic        C7M,
  output logic        nPRAS,
  output logic        nPCAS,
  output logic [7:0]  MA,
  output logic        nWE,
  output logic        nEN80,
  output logic        nWE80,
  output logic        nC07X,
  inout  wire  [7:0]  MD,
  input  logic [7:0]  VD,
  input  logic [15:0] VID_ADDR,
  input  logic        VID_AUX,
  output logic [7:0]  VID_DATA,
  output logic        VID_VALID
);
  localparam int CW = (CYCLES_PER_LINE > 1) ? $clog2(CYCLES_PER_LINE) : 1;
  localparam logic [CW-1:0] CYC_LAST = CW'(CYCLES_PER_LINE - 1);

  typedef enum logic {ST_HALT, ST_RUN} state_t;
  state_t state, state_nxt;

  logic [3:0]    t, t_nxt, p, last_t;
  logic [CW-1:0] cyc, cyc_nxt;
  logic          end_cyc, take, in_phi1, active;
  logic [15:0]   vid_addr_q, req_addr_q, vaddr, raddr, addr;
  logic          vid_aux_q, req_we_q, req_aux_q, busy_q, rwe, raux;
  logic [7:0]    req_wdata_q, rwdata, ma_nxt, md_q;
  logic          nras_nxt, ncas_nxt, nen_nxt, nwe_nxt, nc07x_nxt, md_oe_nxt, md_oe;

  assign MD        = md_oe ? md_q : 8'hzz;
  assign host.BUSY = busy_q;

  always_ff @(posedge C14M) begin
    if (RST) state <= ST_HALT;
    else     state <= state_nxt;
  end

  // Everything is computed for the tick being entered so every output is a plain register.
  always_comb begin
    state_nxt = ST_RUN;
    last_t    = ((LONG_CYCLE_EN != 0) && (cyc == CYC_LAST)) ? 4'd15 : 4'd13;
    end_cyc   = (state == ST_RUN) && (t == last_t);
    t_nxt     = ((state != ST_RUN) || end_cyc) ? 4'd0 : t + 4'd1;
    cyc_nxt   = cyc;
    if (end_cyc) cyc_nxt = (cyc == CYC_LAST) ? '0 : cyc + CW'(1);

    take    = (state == ST_RUN) && (t == 4'd6) && host.REQ;
    active  = take || busy_q;
    in_phi1 = (t_nxt <= 4'd6);
    p       = in_phi1 ? t_nxt : t_nxt - 4'd7;

    vaddr  = (t_nxt == 4'd0) ? VID_ADDR : vid_addr_q;
    raddr  = take ? host.REQ_ADDR  : req_addr_q;
    rwe    = take ? host.REQ_WE    : req_we_q;
    raux   = take ? host.REQ_AUX   : req_aux_q;
    rwdata = take ? host.REQ_WDATA : req_wdata_q;
    addr   = in_phi1 ? vaddr : raddr;

    ma_nxt    = (p < 4'd3) ? addr[7:0] : addr[15:8];
    nras_nxt  = (p == 4'd0);
    ncas_nxt  = (p < 4'd3);
    nen_nxt   = 1'b1;
    nwe_nxt   = 1'b1;
    nc07x_nxt = 1'b1;
    md_oe_nxt = 1'b0;
    if (in_phi1) begin
      nen_nxt = !(vid_aux_q && (p != 4'd0));
    end else begin
      nen_nxt   = !(active && raux && (p != 4'd0));
      nc07x_nxt = !(active && (p != 4'd0) && (raddr[15:4] == 12'hC07));
      nwe_nxt   = !(active && rwe && (p >= 4'd2));
      md_oe_nxt = active && rwe && (p != 4'd0);
    end
  end

  always_ff @(posedge C14M) begin
    if (RST) begin
      t <= '0;  cyc <= '0;
      PHI1 <= 1'b1;  PHI0 <= 1'b0;  Q3 <= 1'b0;  C7M <= 1'b0;
      nPRAS <= 1'b1; nPCAS <= 1'b1; nWE <= 1'b1; nEN80 <= 1'b1;
      nWE80 <= 1'b1; nC07X <= 1'b1; MA <= '0;
      md_oe <= 1'b0; md_q <= '0;
      busy_q <= 1'b0; host.ACK <= 1'b0; host.RDATA <= '0;
      VID_DATA <= '0; VID_VALID <= 1'b0;
      vid_addr_q <= '0; vid_aux_q <= 1'b0;
      req_addr_q <= '0; req_we_q <= 1'b0; req_aux_q <= 1'b0; req_wdata_q <= '0;
    end else begin
      t     <= t_nxt;
      cyc   <= cyc_nxt;
      PHI1  <= in_phi1;
      PHI0  <= !in_phi1;
      Q3    <= (p <= 4'd3);
      C7M   <= t_nxt[0];
      nPRAS <= nras_nxt;
      nPCAS <= ncas_nxt;
      nWE   <= nwe_nxt;
      nEN80 <= nen_nxt;
      nWE80 <= nwe_nxt | nen_nxt;
      nC07X <= nc07x_nxt;
      MA    <= ma_nxt;
      md_oe <= md_oe_nxt;
      md_q  <= rwdata;
      if (t_nxt == 4'd0) begin
        vid_addr_q <= VID_ADDR;
        vid_aux_q  <= VID_AUX;
      end
      VID_VALID <= (state == ST_RUN) && (t == 4'd6);
      if ((state == ST_RUN) && (t == 4'd6)) VID_DATA <= VD;
      if (take) begin
        req_addr_q  <= host.REQ_ADDR;
        req_we_q    <= host.REQ_WE;
        req_aux_q   <= host.REQ_AUX;
        req_wdata_q <= host.REQ_WDATA;
        busy_q      <= 1'b1;
      end else if (end_cyc) begin
        busy_q <= 1'b0;
      end
      host.ACK <= end_cyc && busy_q;
      if (end_cyc && busy_q && !req_we_q) host.RDATA <= MD;
    end
  end
endmodule
